// File: rtl/ptw_arbiter.sv
// Shares one page table walker between the ITLB and DTLB miss ports.
// Round-robin grant, one walk in flight, PTE routed back to the issuing TLB only.
module ptw_arbiter #(
  parameter int ADDR_W = 32,
  parameter int PTE_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              itlb_req_valid_i,
  output logic              itlb_req_ready_o,
  input  logic [ADDR_W-1:0] itlb_vaddr_i,
  output logic              itlb_resp_valid_o,
  input  logic              itlb_resp_ready_i,
  output logic [PTE_W-1:0]  itlb_pte_o,
  input  logic              dtlb_req_valid_i,
  output logic              dtlb_req_ready_o,
  input  logic [ADDR_W-1:0] dtlb_vaddr_i,
  output logic              dtlb_resp_valid_o,
  input  logic              dtlb_resp_ready_i,
  output logic [PTE_W-1:0]  dtlb_pte_o,
  output logic              ptw_req_valid_o,
  input  logic              ptw_req_ready_i,
  output logic [ADDR_W-1:0] ptw_vaddr_o,
  input  logic              ptw_resp_valid_i,
  output logic              ptw_resp_ready_o,
  input  logic [PTE_W-1:0]  ptw_pte_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  itlb_walk_cnt_o,
  output logic [CNT_W-1:0]  dtlb_walk_cnt_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_e;

  state_e              state_q;
  logic                owner_q;       // 0 = ITLB, 1 = DTLB
  logic                last_q;
  logic [ADDR_W-1:0]   vaddr_q;
  logic [PTE_W-1:0]    ipte_q, dpte_q;
  logic                req_vld_q, resp_rdy_q, ivld_q, dvld_q, busy_q;
  logic [CNT_W-1:0]    icnt_q, dcnt_q;
  logic                grant_d, accept_d, owner_rdy;

  always_comb begin
    grant_d = 1'b0;
    if (itlb_req_valid_i && dtlb_req_valid_i) grant_d = ~last_q;
    else if (dtlb_req_valid_i)                grant_d = 1'b1;
  end

  assign accept_d  = (state_q == IDLE) && (itlb_req_valid_i || dtlb_req_valid_i);
  assign owner_rdy = owner_q ? dtlb_resp_ready_i : itlb_resp_ready_i;

  // rst gates the combinational readies so they are 0 while reset is held.
  assign itlb_req_ready_o = !rst && accept_d && !grant_d;
  assign dtlb_req_ready_o = !rst && accept_d &&  grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      vaddr_q    <= '0;
      ipte_q     <= '0;
      dpte_q     <= '0;
      req_vld_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      ivld_q     <= 1'b0;
      dvld_q     <= 1'b0;
      busy_q     <= 1'b0;
      icnt_q     <= '0;
      dcnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept_d) begin
          owner_q   <= grant_d;
          vaddr_q   <= grant_d ? dtlb_vaddr_i : itlb_vaddr_i;
          req_vld_q <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= ISSUE;
        end
        ISSUE: if (ptw_req_ready_i) begin
          req_vld_q  <= 1'b0;
          resp_rdy_q <= 1'b1;
          state_q    <= WAIT;
        end
        WAIT: if (ptw_resp_valid_i) begin
          resp_rdy_q <= 1'b0;
          if (owner_q) begin dpte_q <= ptw_pte_i; dvld_q <= 1'b1; end
          else         begin ipte_q <= ptw_pte_i; ivld_q <= 1'b1; end
          state_q <= RETURN;
        end
        RETURN: if (owner_rdy) begin
          ivld_q <= 1'b0;
          dvld_q <= 1'b0;
          last_q <= owner_q;
          busy_q <= 1'b0;
          if (owner_q) begin if (~&dcnt_q) dcnt_q <= dcnt_q + 1'b1; end
          else         begin if (~&icnt_q) icnt_q <= icnt_q + 1'b1; end
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          req_vld_q  <= 1'b0;
          resp_rdy_q <= 1'b0;
          ivld_q     <= 1'b0;
          dvld_q     <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ptw_req_valid_o   = req_vld_q;
  assign ptw_vaddr_o       = vaddr_q;
  assign ptw_resp_ready_o  = resp_rdy_q;
  assign itlb_resp_valid_o = ivld_q;
  assign dtlb_resp_valid_o = dvld_q;
  assign itlb_pte_o        = ipte_q;
  assign dtlb_pte_o        = dpte_q;
  assign busy_o            = busy_q;
  assign itlb_walk_cnt_o   = icnt_q;
  assign dtlb_walk_cnt_o   = dcnt_q;
endmodule

// File: tb/tb_ptw_arbiter.sv
// Bench for ptw_arbiter: directed walk table, hand-written corner sequences and a
// random phase, all watched by a transaction-level reference model.
module tb_ptw_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        itlb_req_valid_i = 0, itlb_resp_ready_i = 1, dtlb_req_valid_i = 0, dtlb_resp_ready_i = 1;
  logic        ptw_req_ready_i = 0, ptw_resp_valid_i = 0;
  logic [31:0] itlb_vaddr_i = 0, dtlb_vaddr_i = 0, ptw_pte_i = 0;
  logic        itlb_req_ready_o, itlb_resp_valid_o, dtlb_req_ready_o, dtlb_resp_valid_o;
  logic        ptw_req_valid_o, ptw_resp_ready_o, busy_o;
  logic [31:0] itlb_pte_o, dtlb_pte_o, ptw_vaddr_o;
  logic [15:0] icnt, dcnt;
  logic        i_rr2, i_rv2, d_rr2, d_rv2, p_qv2, p_sr2, busy2;
  logic [31:0] ipte2, dpte2, pva2;
  logic [1:0]  icnt2, dcnt2;

  always #5 clk = ~clk;

  ptw_arbiter #(.ADDR_W(32), .PTE_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_ready_o(itlb_req_ready_o), .itlb_vaddr_i(itlb_vaddr_i),
    .itlb_resp_valid_o(itlb_resp_valid_o), .itlb_resp_ready_i(itlb_resp_ready_i), .itlb_pte_o(itlb_pte_o),
    .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_ready_o(dtlb_req_ready_o), .dtlb_vaddr_i(dtlb_vaddr_i),
    .dtlb_resp_valid_o(dtlb_resp_valid_o), .dtlb_resp_ready_i(dtlb_resp_ready_i), .dtlb_pte_o(dtlb_pte_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i), .ptw_vaddr_o(ptw_vaddr_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_ready_o(ptw_resp_ready_o), .ptw_pte_i(ptw_pte_i),
    .busy_o(busy_o), .itlb_walk_cnt_o(icnt), .dtlb_walk_cnt_o(dcnt));

  // Same stimulus, 2-bit counters: used only to observe saturation.
  ptw_arbiter #(.ADDR_W(32), .PTE_W(32), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_ready_o(i_rr2), .itlb_vaddr_i(itlb_vaddr_i),
    .itlb_resp_valid_o(i_rv2), .itlb_resp_ready_i(itlb_resp_ready_i), .itlb_pte_o(ipte2),
    .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_ready_o(d_rr2), .dtlb_vaddr_i(dtlb_vaddr_i),
    .dtlb_resp_valid_o(d_rv2), .dtlb_resp_ready_i(dtlb_resp_ready_i), .dtlb_pte_o(dpte2),
    .ptw_req_valid_o(p_qv2), .ptw_req_ready_i(ptw_req_ready_i), .ptw_vaddr_o(pva2),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_ready_o(p_sr2), .ptw_pte_i(ptw_pte_i),
    .busy_o(busy2), .itlb_walk_cnt_o(icnt2), .dtlb_walk_cnt_o(dcnt2));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    total++; bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // ---------------- reference model: one walk tracked as a transaction ----------------
  bit          m_busy, m_owner, m_issued, m_got, m_last, exp_gi, exp_gd;
  logic [31:0] m_vaddr, m_pte_i, m_pte_d;
  int          m_ci, m_cd;
  logic [31:0] acc_q[$];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always begin
    @(negedge clk); #2;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_issued = 0; m_got = 0; m_last = 1;
      m_pte_i = 0; m_pte_d = 0; m_ci = 0; m_cd = 0;
    end else begin
      exp_gi = 0; exp_gd = 0;
      if (!m_busy) begin
        if (itlb_req_valid_i && dtlb_req_valid_i) begin exp_gi = m_last; exp_gd = !m_last; end
        else begin exp_gi = itlb_req_valid_i; exp_gd = dtlb_req_valid_i; end
      end
      chk("m_itlb_req_ready", itlb_req_ready_o, exp_gi);
      chk("m_dtlb_req_ready", dtlb_req_ready_o, exp_gd);
      chk("m_ptw_req_valid", ptw_req_valid_o, m_busy && !m_issued);
      if (m_busy && !m_issued) chk("m_ptw_vaddr", ptw_vaddr_o, m_vaddr);
      chk("m_ptw_resp_ready", ptw_resp_ready_o, m_issued && !m_got);
      chk("m_itlb_resp_valid", itlb_resp_valid_o, m_got && !m_owner);
      chk("m_dtlb_resp_valid", dtlb_resp_valid_o, m_got && m_owner);
      chk("m_itlb_pte", itlb_pte_o, m_pte_i);
      chk("m_dtlb_pte", dtlb_pte_o, m_pte_d);
      chk("m_busy", busy_o, m_busy);
      chk("m_icnt", icnt, sat(m_ci, 65535));
      chk("m_dcnt", dcnt, sat(m_cd, 65535));
      chk("m_icnt2", icnt2, sat(m_ci, 3));
      chk("m_dcnt2", dcnt2, sat(m_cd, 3));
      // advance the model by whatever handshake the coming edge completes
      if (m_got) begin
        if (m_owner ? dtlb_resp_ready_i : itlb_resp_ready_i) begin
          m_busy = 0; m_issued = 0; m_got = 0; m_last = m_owner;
          if (m_owner) m_cd++; else m_ci++;
        end
      end else if (m_issued) begin
        if (ptw_resp_valid_i) begin
          m_got = 1;
          if (m_owner) m_pte_d = ptw_pte_i; else m_pte_i = ptw_pte_i;
        end
      end else if (m_busy) begin
        if (ptw_req_ready_i) m_issued = 1;
      end else if (exp_gi || exp_gd) begin
        m_busy = 1; m_owner = exp_gd;
        m_vaddr = exp_gd ? dtlb_vaddr_i : itlb_vaddr_i;
        acc_q.push_back(m_vaddr);
      end
    end
  end

  // ---------------- drivers (all start and return at a negedge) ----------------
  task automatic tlb_req(input bit sel, input logic [31:0] va);
    bit hs = 0;
    if (sel) begin dtlb_req_valid_i = 1; dtlb_vaddr_i = va; end
    else     begin itlb_req_valid_i = 1; itlb_vaddr_i = va; end
    for (int n = 0; n < 400; n++) begin
      #1; hs = sel ? dtlb_req_ready_o : itlb_req_ready_o;
      @(negedge clk);
      if (hs) break;
    end
    if (sel) dtlb_req_valid_i = 0; else itlb_req_valid_i = 0;
    if (!hs) tmo(sel ? "dtlb_req" : "itlb_req");
  endtask

  task automatic walker(input int rdly, input int pdly, input logic [31:0] pte);
    bit hs = 0;
    for (int n = 0; n < 400 && !ptw_req_valid_o; n++) @(negedge clk);
    if (!ptw_req_valid_o) begin tmo("walker_req"); return; end
    repeat (rdly) @(negedge clk);
    ptw_req_ready_i = 1;
    @(negedge clk);
    ptw_req_ready_i = 0;
    repeat (pdly) @(negedge clk);
    ptw_resp_valid_i = 1; ptw_pte_i = pte;
    for (int n = 0; n < 400; n++) begin
      #1; hs = ptw_resp_ready_o;
      @(negedge clk);
      if (hs) break;
    end
    ptw_resp_valid_i = 0;
    if (!hs) tmo("walker_resp");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      if (!busy_o) return;
      @(negedge clk);
    end
    tmo("wait_idle");
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    itlb_req_valid_i = 0; dtlb_req_valid_i = 0; ptw_req_ready_i = 0; ptw_resp_valid_i = 0;
    itlb_resp_ready_i = 1; dtlb_resp_ready_i = 1;
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_irdy"}, itlb_req_ready_o, 0);   chk({tag, "_drdy"}, dtlb_req_ready_o, 0);
    chk({tag, "_irv"}, itlb_resp_valid_o, 0);   chk({tag, "_drv"}, dtlb_resp_valid_o, 0);
    chk({tag, "_pqv"}, ptw_req_valid_o, 0);     chk({tag, "_psr"}, ptw_resp_ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);             chk({tag, "_pva"}, ptw_vaddr_o, 0);
    chk({tag, "_ipte"}, itlb_pte_o, 0);         chk({tag, "_dpte"}, dtlb_pte_o, 0);
    chk({tag, "_icnt"}, icnt, 0);               chk({tag, "_dcnt"}, dcnt, 0);
  endtask

  typedef struct {
    bit          sel;
    logic [31:0] va;
    int          rdly, pdly;
    logic [31:0] pte;
    int          exp_ci, exp_cd, exp_ci2;
  } walk_t;

  initial begin
    walk_t       tbl[6];
    logic [31:0] lastpte[2];
    logic [31:0] held;
    logic [31:0] ord[6];
    bit          done;

    tbl[0] = '{0, 32'h00403000, 2, 3, 32'h001000CF, 1, 0, 1};
    tbl[1] = '{1, 32'h00801000, 0, 0, 32'h00000000, 1, 1, 1};
    tbl[2] = '{0, 32'h00404000, 1, 0, 32'h00000000, 2, 1, 2};
    tbl[3] = '{0, 32'h7FFFF000, 0, 1, 32'hFFFFFFFF, 3, 1, 3};
    tbl[4] = '{0, 32'h00000000, 0, 0, 32'h12345678, 4, 1, 3};
    tbl[5] = '{0, 32'hFFFFF000, 3, 2, 32'h0000A5A5, 5, 1, 3};

    // reset state, sampled while reset is still asserted
    itlb_req_valid_i = 1; dtlb_req_valid_i = 1;
    #3; chk_zero("rst0");
    itlb_req_valid_i = 0; dtlb_req_valid_i = 0;
    @(negedge clk); @(negedge clk); rst = 0;

    // directed walk table
    lastpte[0] = 0; lastpte[1] = 0;
    foreach (tbl[k]) begin
      fork
        tlb_req(tbl[k].sel, tbl[k].va);
        walker(tbl[k].rdly, tbl[k].pdly, tbl[k].pte);
      join
      wait_idle();
      lastpte[tbl[k].sel] = tbl[k].pte;
      chk("tbl_ipte", itlb_pte_o, lastpte[0]);
      chk("tbl_dpte", dtlb_pte_o, lastpte[1]);
      chk("tbl_icnt", icnt, tbl[k].exp_ci);
      chk("tbl_dcnt", dcnt, tbl[k].exp_cd);
      chk("tbl_icnt2", icnt2, tbl[k].exp_ci2);
    end

    // minimum round trip with an always-ready walker and TLB
    do_reset();
    ptw_req_ready_i = 1;
    itlb_req_valid_i = 1; itlb_vaddr_i = 32'h00ABC000;
    #1; chk("lat_c0_accept", itlb_req_ready_o, 1);
    @(negedge clk); itlb_req_valid_i = 0;
    chk("lat_c1_reqv", ptw_req_valid_o, 1);
    chk("lat_c1_vaddr", ptw_vaddr_o, 32'h00ABC000);
    chk("lat_c1_rspr", ptw_resp_ready_o, 0);
    @(negedge clk);
    chk("lat_c2_reqv", ptw_req_valid_o, 0);
    chk("lat_c2_rspr", ptw_resp_ready_o, 1);
    ptw_resp_valid_i = 1; ptw_pte_i = 32'h0C0FFEE1;
    @(negedge clk); ptw_resp_valid_i = 0;
    chk("lat_c3_irv", itlb_resp_valid_o, 1);
    chk("lat_c3_pte", itlb_pte_o, 32'h0C0FFEE1);
    @(negedge clk);
    chk("lat_c4_irv", itlb_resp_valid_o, 0);
    dtlb_req_valid_i = 1; dtlb_vaddr_i = 32'h00DEF000;
    #1; chk("lat_c4_next_accept", dtlb_req_ready_o, 1);
    @(negedge clk); dtlb_req_valid_i = 0; ptw_req_ready_i = 0;
    walker(0, 0, 32'h00000011);
    wait_idle();

    // simultaneous and continuous requesters: strict alternation from I
    do_reset();
    acc_q.delete();
    fork
      for (int k = 0; k < 3; k++) tlb_req(0, 32'h10000000 + k);
      for (int k = 0; k < 3; k++) tlb_req(1, 32'h20000000 + k);
      for (int k = 0; k < 6; k++) walker(k % 2, 1, 32'h00A00000 + k);
    join
    wait_idle();
    ord = '{32'h10000000, 32'h20000000, 32'h10000001, 32'h20000001, 32'h10000002, 32'h20000002};
    chk("rr_count", acc_q.size(), 6);
    for (int k = 0; k < 6 && k < acc_q.size(); k++) chk("rr_order", acc_q[k], ord[k]);
    chk("rr_icnt", icnt, 3);
    chk("rr_dcnt", dcnt, 3);
    chk("rr_ipte", itlb_pte_o, 32'h00A00004);
    chk("rr_dpte", dtlb_pte_o, 32'h00A00005);

    // ITLB stalls its response while DTLB waits
    do_reset();
    itlb_resp_ready_i = 0;
    fork
      tlb_req(0, 32'h00111000);
      begin @(negedge clk); tlb_req(1, 32'h00222000); end
      begin walker(0, 0, 32'hAAAA0001); walker(0, 0, 32'hBBBB0002); end
      begin
        for (int n = 0; n < 400 && !itlb_resp_valid_o; n++) @(negedge clk);
        if (!itlb_resp_valid_o) tmo("stall_wait");
        held = itlb_pte_o;
        chk("stall_pte", held, 32'hAAAA0001);
        for (int n = 0; n < 5; n++) begin
          #1;
          chk("stall_irv", itlb_resp_valid_o, 1);
          chk("stall_hold", itlb_pte_o, held);
          chk("stall_drdy", dtlb_req_ready_o, 0);
          chk("stall_drv", dtlb_resp_valid_o, 0);
          @(negedge clk);
        end
        itlb_resp_ready_i = 1;
        @(negedge clk);
        #1; chk("stall_d_accept", dtlb_req_ready_o, 1);
      end
    join
    wait_idle();
    chk("stall_dpte", dtlb_pte_o, 32'hBBBB0002);
    chk("stall_ipte_keep", itlb_pte_o, 32'hAAAA0001);

    // asynchronous reset while waiting for the walker
    do_reset();
    fork
      tlb_req(0, 32'h00555000);
      begin
        for (int n = 0; n < 400 && !ptw_req_valid_o; n++) @(negedge clk);
        ptw_req_ready_i = 1; @(negedge clk); ptw_req_ready_i = 0;
      end
    join
    chk("ar_in_wait", ptw_resp_ready_o, 1);
    #3 rst = 1;
    #1 chk_zero("ar");
    @(negedge clk); @(negedge clk); rst = 0;
    ptw_resp_valid_i = 1; ptw_pte_i = 32'hDEAD0BAD;
    for (int n = 0; n < 2; n++) begin
      #1; chk("ar_late_resp_ignored", ptw_resp_ready_o, 0);
      @(negedge clk);
    end
    ptw_resp_valid_i = 0;
    fork
      tlb_req(1, 32'h00666000);
      walker(0, 0, 32'h00777007);
    join
    wait_idle();
    chk("ar_dpte", dtlb_pte_o, 32'h00777007);
    chk("ar_ipte", itlb_pte_o, 0);
    chk("ar_dcnt", dcnt, 1);
    chk("ar_icnt", icnt, 0);

    // random traffic, checked continuously by the model
    do_reset();
    done = 0;
    fork
      begin
        fork
          for (int k = 0; k < 40; k++) begin repeat ($urandom_range(0, 3)) @(negedge clk); tlb_req(0, $urandom); end
          for (int k = 0; k < 40; k++) begin repeat ($urandom_range(0, 3)) @(negedge clk); tlb_req(1, $urandom); end
          for (int k = 0; k < 80; k++) walker($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        join
        done = 1;
      end
      while (!done) begin
        itlb_resp_ready_i = $urandom_range(0, 1);
        dtlb_resp_ready_i = $urandom_range(0, 1);
        @(negedge clk);
      end
    join
    itlb_resp_ready_i = 1; dtlb_resp_ready_i = 1;
    wait_idle();
    chk("rnd_icnt", icnt, 40);
    chk("rnd_dcnt", dcnt, 40);
    chk("rnd_icnt2", icnt2, 3);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
